// File: rtl/fifo_pkg.sv
// Shared constants for the 16-entry FIFO pointer/flag controller and its
// occupancy datapath.
package fifo_pkg;

    localparam int FIFO_ADDR_W   = 4;
    localparam int FIFO_PTR_W    = FIFO_ADDR_W + 1;
    localparam int FIFO_DEPTH    = 1 << FIFO_ADDR_W;
    localparam int FIFO_AF_LEVEL = 14;
    localparam int FIFO_AE_LEVEL = 2;

    typedef logic [FIFO_PTR_W-1:0] fifo_ptr_t;

endpackage : fifo_pkg

// File: rtl/fifo_ptr_ctrl_if.sv
// Request/ack, address, pointer and flag bundle of fifo_ptr_ctrl.
// The almost_full/almost_empty members exist only with FIFO_ALMOST_FLAGS_EN.
interface fifo_ptr_ctrl_if #(
    parameter int ADDR_W = 4
);

    logic              wr_en;
    logic              rd_en;
    logic              wr_ack;
    logic              rd_ack;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              sub_sel;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic              almost_full;
    logic              almost_empty;
`endif

    modport master (
        output wr_en, rd_en,
        input  wr_ack, rd_ack, wr_addr, rd_addr, wr_ptr, rd_ptr,
        input  sub_sel, full, empty, overflow, underflow
`ifdef FIFO_ALMOST_FLAGS_EN
        , input almost_full, almost_empty
`endif
    );

    modport slave (
        input  wr_en, rd_en,
        output wr_ack, rd_ack, wr_addr, rd_addr, wr_ptr, rd_ptr,
        output sub_sel, full, empty, overflow, underflow
`ifdef FIFO_ALMOST_FLAGS_EN
        , output almost_full, almost_empty
`endif
    );

endinterface : fifo_ptr_ctrl_if

// File: rtl/fifo_ptr_cnt.sv
// Wrapping PTR_W-bit pointer register with increment enable. next_ptr exposes
// the value the register takes on the coming edge so flags can be precomputed.
module fifo_ptr_cnt #(
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] next_ptr
);

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] next_ptr_s;

    // Next pointer value; natural overflow of the adder gives the modulo wrap
    always_comb begin
        next_ptr_s = ptr_r;
        if (inc) begin
            next_ptr_s = ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            next_ptr_s = ptr_r;
        end
    end

    // Pointer register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {PTR_W{1'b0}};
        end else begin
            ptr_r <= next_ptr_s;
        end
    end

    assign ptr      = ptr_r;
    assign next_ptr = next_ptr_s;

endmodule : fifo_ptr_cnt

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and flag controller for the 16-entry FIFO. Optional registered
// almost_full/almost_empty outputs are built when FIFO_ALMOST_FLAGS_EN is defined.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    parameter int AF_LEVEL = FIFO_AF_LEVEL,
    parameter int AE_LEVEL = FIFO_AE_LEVEL
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    fifo_ptr_ctrl_if.slave bus
);

    localparam int PTR_W = ADDR_W + 1;

    logic             wr_ack_s;
    logic             rd_ack_s;
    logic [PTR_W-1:0] wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_s;
    logic [PTR_W-1:0] next_wr_s;
    logic [PTR_W-1:0] next_rd_s;
    logic             next_empty_s;
    logic             next_full_s;

    logic             full_r;
    logic             empty_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             sub_sel_r;

    // Accept decision on the registered flags; a read frees a slot for a write
    // in the same cycle, and nothing is acknowledged while reset is held
    always_comb begin
        wr_ack_s = 1'b0;
        rd_ack_s = 1'b0;
        if (rst_n) begin
            wr_ack_s = bus.wr_en & (~full_r | bus.rd_en);
            rd_ack_s = bus.rd_en & ~empty_r;
        end else begin
            wr_ack_s = 1'b0;
            rd_ack_s = 1'b0;
        end
    end

    fifo_ptr_cnt #(
        .PTR_W    (PTR_W)
    ) u_wr_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (wr_ack_s),
        .ptr      (wr_ptr_s),
        .next_ptr (next_wr_s)
    );

    fifo_ptr_cnt #(
        .PTR_W    (PTR_W)
    ) u_rd_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (rd_ack_s),
        .ptr      (rd_ptr_s),
        .next_ptr (next_rd_s)
    );

    // Flags from next-state pointers: equal means empty, equal address with
    // differing wrap bit means a full lap ahead
    always_comb begin
        next_empty_s = (next_wr_s == next_rd_s);
        next_full_s  = (next_wr_s[ADDR_W] != next_rd_s[ADDR_W]) &&
                       (next_wr_s[ADDR_W-1:0] == next_rd_s[ADDR_W-1:0]);
    end

    // Flag, reject-pulse and subtractor-enable registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            sub_sel_r   <= 1'b0;
        end else begin
            full_r      <= next_full_s;
            empty_r     <= next_empty_s;
            overflow_r  <= bus.wr_en & ~wr_ack_s;
            underflow_r <= bus.rd_en & ~rd_ack_s;
            sub_sel_r   <= 1'b1;
        end
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic [PTR_W-1:0] AF_LVL_C = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_LVL_C = PTR_W'(AE_LEVEL);

    logic [PTR_W-1:0] next_count_s;
    logic             almost_full_r;
    logic             almost_empty_r;

    // Occupancy after this edge, modulo the pointer width like the subtractor
    always_comb begin
        next_count_s = next_wr_s - next_rd_s;
    end

    // Threshold flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            almost_full_r  <= (next_count_s >= AF_LVL_C);
            almost_empty_r <= (next_count_s <= AE_LVL_C);
        end
    end

    assign bus.almost_full  = almost_full_r;
    assign bus.almost_empty = almost_empty_r;
`endif

    assign bus.wr_ack    = wr_ack_s;
    assign bus.rd_ack    = rd_ack_s;
    assign bus.wr_ptr    = wr_ptr_s;
    assign bus.rd_ptr    = rd_ptr_s;
    assign bus.wr_addr   = wr_ptr_s[ADDR_W-1:0];
    assign bus.rd_addr   = rd_ptr_s[ADDR_W-1:0];
    assign bus.full      = full_r;
    assign bus.empty     = empty_r;
    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
    assign bus.sub_sel   = sub_sel_r;

endmodule : fifo_ptr_ctrl

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl: directed and random traffic compared
// against an occupancy-count model of the FIFO.
module tb_fifo_ptr_ctrl;
    import fifo_pkg::*;

    logic clk;
    logic rst_n;

    fifo_ptr_ctrl_if #(.ADDR_W(FIFO_ADDR_W)) bus ();

    fifo_ptr_ctrl #(.ADDR_W(FIFO_ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: number of stored entries and totals of accepted accesses
    int cnt;
    int wr_total;
    int rd_total;
    bit ov_m;
    bit un_m;
    bit sub_m;
    bit full_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cnt      = 0;
        wr_total = 0;
        rd_total = 0;
        ov_m     = 1'b0;
        un_m     = 1'b0;
        sub_m    = 1'b0;
    endtask

    task automatic check_regs();
        chk("wr_ptr",    32'(bus.wr_ptr),   32'(wr_total % 32));
        chk("rd_ptr",    32'(bus.rd_ptr),   32'(rd_total % 32));
        chk("wr_addr",   32'(bus.wr_addr),  32'(wr_total % 16));
        chk("rd_addr",   32'(bus.rd_addr),  32'(rd_total % 16));
        chk("full",      32'(bus.full),     32'(cnt == FIFO_DEPTH));
        chk("empty",     32'(bus.empty),    32'(cnt == 0));
        chk("overflow",  32'(bus.overflow), 32'(ov_m));
        chk("underflow", 32'(bus.underflow),32'(un_m));
        chk("sub_sel",   32'(bus.sub_sel),  32'(sub_m));
`ifdef FIFO_ALMOST_FLAGS_EN
        chk("almost_full",  32'(bus.almost_full),  32'(cnt >= FIFO_AF_LEVEL));
        chk("almost_empty", 32'(bus.almost_empty), 32'(cnt <= FIFO_AE_LEVEL));
`endif
    endtask

    // Entered at a falling edge: drive, check acks, clock, check state, return at next falling edge
    task automatic step(input bit w, input bit r);
        bit wa;
        bit ra;
        bus.wr_en = w;
        bus.rd_en = r;
        ra = r && (cnt > 0);
        wa = w && ((cnt < FIFO_DEPTH) || r);
        #1;
        chk("wr_ack", 32'(bus.wr_ack), 32'(wa));
        chk("rd_ack", 32'(bus.rd_ack), 32'(ra));
        cnt      = cnt + int'(wa) - int'(ra);
        wr_total = wr_total + int'(wa);
        rd_total = rd_total + int'(ra);
        ov_m     = w && !wa;
        un_m     = r && !ra;
        sub_m    = 1'b1;
        if (cnt == FIFO_DEPTH) full_seen = 1'b1;
        @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b0;
        model_reset();

        // Held in reset with a write request: nothing acknowledged, reset values
        @(negedge clk);
        #1;
        chk("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
        check_regs();
        @(negedge clk);
        bus.wr_en = 1'b0;
        rst_n     = 1'b1;

        // Idle after release: sub_sel rises, no pulses
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Fill to full, then one rejected write
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        chk("fill_wr_ptr", 32'(bus.wr_ptr), 32'd16);
        chk("fill_full",   32'(bus.full),   32'd1);
        step(1'b1, 1'b0);
        chk("ovf_wr_ptr", 32'(bus.wr_ptr), 32'd16);
        step(1'b0, 1'b0);

        // Simultaneous read+write while full
        step(1'b1, 1'b1);
        chk("full_rw_wr_ptr", 32'(bus.wr_ptr), 32'd17);
        chk("full_rw_rd_ptr", 32'(bus.rd_ptr), 32'd1);
        chk("full_rw_full",   32'(bus.full),   32'd1);

        // Drain, then one rejected read
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Simultaneous read+write while empty: only the write goes through
        step(1'b1, 1'b1);
        chk("empty_rw_empty", 32'(bus.empty), 32'd0);
        step(1'b0, 1'b1);

        // Alternating write/read pairs across the pointer wrap
        full_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b1);
        end
        chk("alt_no_full", 32'(full_seen), 32'd0);

        // Random traffic, write-biased then read-biased
        for (int i = 0; i < 400; i++) begin
            if (i < 200) step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
            else         step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7);
        end

        // Ten writes, then reset pulsed low between edges
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        #2;
        rst_n     = 1'b0;
        bus.wr_en = 1'b1;
        #1;
        model_reset();
        chk("midrst_wr_ack", 32'(bus.wr_ack), 32'd0);
        check_regs();
        @(negedge clk);
        bus.wr_en = 1'b0;
        rst_n     = 1'b1;
        step(1'b0, 1'b0);

`ifdef FIFO_ALMOST_FLAGS_EN
        // Almost-full threshold crossing and release
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
        chk("af_set", 32'(bus.almost_full), 32'd1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("af_clr", 32'(bus.almost_full), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_fifo_ptr_ctrl
